// File: rtl/depth_test_unit.sv
// Z-buffer depth test: read stored depth, compare, write depth+colour on pass.
// Also sweeps the depth buffer to the far plane on request.
module depth_test_unit #(
    parameter int                   ADDR_W      = 26,
    parameter int                   DEPTH_W     = 32,
    parameter int                   NUM_PIXELS  = 307200,
    parameter logic [DEPTH_W-1:0]   CLEAR_DEPTH = DEPTH_W'(32'h7FFF_FFFF)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic [23:0]        in_color,
    input  logic [DEPTH_W-1:0] in_depth,
    input  logic               done_in,
    input  logic               clear_start,
    output logic               stall_out,
    output logic               zb_req,
    output logic               zb_we,
    output logic [ADDR_W-1:0]  zb_addr,
    output logic [DEPTH_W-1:0] zb_wdata,
    input  logic               zb_ack,
    input  logic [DEPTH_W-1:0] zb_rdata,
    output logic               fb_req,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [23:0]        fb_wdata,
    input  logic               fb_ack,
    output logic               clear_busy,
    output logic               done_out,
    output logic [31:0]        pass_count,
    output logic [31:0]        fail_count
);

    typedef enum logic [2:0] {IDLE, RD, CMP, WR, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIXELS - 1);

    state_t             state;
    logic               clear_pend;
    logic               done_pend;
    logic               zb_done;
    logic               fb_done;
    logic [ADDR_W-1:0]  frag_addr;
    logic [23:0]        frag_color;
    logic [DEPTH_W-1:0] frag_depth;
    logic [DEPTH_W-1:0] stored;
    logic [ADDR_W-1:0]  clr_cnt;
    logic               take;
    logic               zb_hit;
    logic               fb_hit;

    assign stall_out = (state != IDLE) || clear_pend;
    assign done_out  = (state == IDLE) && done_pend;
    assign take      = (state == IDLE) && in_valid && !stall_out;
    assign zb_hit    = zb_req && zb_ack;
    assign fb_hit    = fb_req && fb_ack;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            clear_pend <= 1'b0;
            done_pend  <= 1'b0;
            zb_done    <= 1'b0;
            fb_done    <= 1'b0;
            frag_addr  <= '0;
            frag_color <= '0;
            frag_depth <= '0;
            stored     <= '0;
            clr_cnt    <= '0;
            zb_req     <= 1'b0;
            zb_we      <= 1'b0;
            zb_addr    <= '0;
            zb_wdata   <= '0;
            fb_req     <= 1'b0;
            fb_addr    <= '0;
            fb_wdata   <= '0;
            clear_busy <= 1'b0;
            pass_count <= '0;
            fail_count <= '0;
        end else begin
            if (clear_start && state != CLEAR)
                clear_pend <= 1'b1;
            if (done_out)
                done_pend <= 1'b0;
            if (done_in)
                done_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (clear_pend) begin
                        state      <= CLEAR;
                        clear_pend <= 1'b0;
                        clear_busy <= 1'b1;
                        clr_cnt    <= '0;
                        pass_count <= '0;
                        fail_count <= '0;
                        zb_req     <= 1'b1;
                        zb_we      <= 1'b1;
                        zb_addr    <= '0;
                        zb_wdata   <= CLEAR_DEPTH;
                    end else if (take) begin
                        state      <= RD;
                        frag_addr  <= in_addr;
                        frag_color <= in_color;
                        frag_depth <= in_depth;
                        zb_req     <= 1'b1;
                        zb_we      <= 1'b0;
                        zb_addr    <= in_addr;
                    end
                end
                RD: begin
                    if (zb_hit) begin
                        stored <= zb_rdata;
                        zb_req <= 1'b0;
                        state  <= CMP;
                    end
                end
                CMP: begin
                    // strictly nearer wins; a tie keeps the stored pixel
                    if ($signed(frag_depth) < $signed(stored)) begin
                        state    <= WR;
                        zb_req   <= 1'b1;
                        zb_we    <= 1'b1;
                        zb_addr  <= frag_addr;
                        zb_wdata <= frag_depth;
                        fb_req   <= 1'b1;
                        fb_addr  <= frag_addr;
                        fb_wdata <= frag_color;
                        zb_done  <= 1'b0;
                        fb_done  <= 1'b0;
                        if (pass_count != 32'hFFFF_FFFF)
                            pass_count <= pass_count + 32'd1;
                    end else begin
                        state <= IDLE;
                        if (fail_count != 32'hFFFF_FFFF)
                            fail_count <= fail_count + 32'd1;
                    end
                end
                WR: begin
                    if (zb_hit) begin
                        zb_req  <= 1'b0;
                        zb_done <= 1'b1;
                    end
                    if (fb_hit) begin
                        fb_req  <= 1'b0;
                        fb_done <= 1'b1;
                    end
                    if ((zb_done || zb_hit) && (fb_done || fb_hit))
                        state <= IDLE;
                end
                CLEAR: begin
                    if (zb_hit) begin
                        if (clr_cnt == LAST) begin
                            state      <= IDLE;
                            zb_req     <= 1'b0;
                            clear_busy <= 1'b0;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                            zb_addr <= clr_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
